an_encoder_sys_6x6: RTL

- Transmit-side counterpart of the 6x6 AN-code (A=37) decoder array.
- Accepts a stream of 13-bit messages and encodes each as codeword = 37*message, using shift-add (m<<5 + m<<2 + m) into 18 bits.
- Assembles 36 codewords into a 6x6 frame, row-major, and presents the whole frame in parallel to the channel/storage side.
- Two ping-pong frame buffers let input streaming continue while a finished frame waits for downstream.

---
 rtl/an_code_pkg.sv | 24 ++
 rtl/an_mul37.sv | 22 ++
 rtl/an_encoder_sys_6x6.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/an_code_pkg.sv
// an_code_pkg: shared constants and types for the A=37 AN-code 6x6 encoder/decoder family.
`default_nettype none

package an_code_pkg;

  localparam int A_N37       = 37;
  localparam int MSG_W       = 13;
  localparam int CW_W        = 18;
  localparam int DIM         = 6;
  localparam int WORDS       = DIM * DIM;
  localparam int MSG_MAX_N37 = 7084;

  typedef logic [CW_W-1:0]  cw_t;
  typedef logic [MSG_W-1:0] msg_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } buf_state_t;

endpackage

`default_nettype wire

// File: rtl/an_mul37.sv
// an_mul37: combinational 37*m shift-add encoder; out-of-range messages encode to 0 with ovf set.
`default_nettype none

module an_mul37
  import an_code_pkg::*;
(
  input  msg_t msg_i,
  output cw_t  cw_o,
  output logic ovf_o
);

  cw_t m_ext;
  cw_t prod;

  assign m_ext = cw_t'(msg_i);
  assign prod  = (m_ext << 5) + (m_ext << 2) + m_ext;
  assign ovf_o = (msg_i > msg_t'(MSG_MAX_N37));
  assign cw_o  = ovf_o ? '0 : prod;

endmodule

`default_nettype wire

// File: rtl/an_encoder_sys_6x6.sv
// an_encoder_sys_6x6: streams messages into ping-pong 6x6 AN-code frames (A=37).
// Optional macro AN_ENC_ERR_INJ_EN adds inj_valid/inj_idx/inj_mask single-word error injection.
`default_nettype none

module an_encoder_sys_6x6
  import an_code_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MSG_W-1:0]      in_msg,
  input  logic                  flush,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [WORDS*CW_W-1:0] frame_cw,
  output logic                  frame_ovf,
  output logic [5:0]            frame_cnt
`ifdef AN_ENC_ERR_INJ_EN
  ,
  input  logic                  inj_valid,
  input  logic [5:0]            inj_idx,
  input  logic [CW_W-1:0]       inj_mask
`endif
);

  buf_state_t state_q [2];
  buf_state_t state_d [2];
  logic [1:0] ovf_q, ovf_d;
  logic [5:0] cnt_q [2];
  logic [5:0] cnt_d [2];
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [5:0] idx_q, idx_d;
  cw_t        mem_q [2][WORDS];

  cw_t        enc_cw;
  cw_t        store_cw;
  logic       enc_ovf;
  buf_state_t wr_state;
  logic       accept;
  logic       close;
  logic       hs;

  an_mul37 u_mul37 (
    .msg_i (in_msg),
    .cw_o  (enc_cw),
    .ovf_o (enc_ovf)
  );

`ifdef AN_ENC_ERR_INJ_EN
  // An index above 35 never matches idx_q, so it is naturally ignored.
  assign store_cw = enc_cw ^ ((inj_valid && (inj_idx == idx_q)) ? inj_mask : '0);
`else
  assign store_cw = enc_cw;
`endif

  assign wr_state    = state_q[wr_sel_q];
  // Ready comes only from registered buffer state; rst_n gating keeps it low while held in reset.
  assign in_ready    = rst_n && (wr_state != FULL);
  assign accept      = in_valid && in_ready;
  assign close       = (accept && ((idx_q == 6'(WORDS - 1)) || flush)) ||
                       (flush && (wr_state == FILLING));
  assign frame_valid = (state_q[rd_sel_q] == FULL);
  assign hs          = frame_valid && frame_ready;

  always_comb begin
    state_d  = state_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    idx_d    = idx_q;
    // Release and close always target different buffers (FULL vs FILLING), so both may apply.
    if (hs) begin
      state_d[rd_sel_q] = EMPTY;
      ovf_d[rd_sel_q]   = 1'b0;
      cnt_d[rd_sel_q]   = '0;
      rd_sel_d          = ~rd_sel_q;
    end
    if (accept) begin
      state_d[wr_sel_q] = FILLING;
      ovf_d[wr_sel_q]   = ovf_q[wr_sel_q] | enc_ovf;
      cnt_d[wr_sel_q]   = idx_q + 6'd1;
      idx_d             = idx_q + 6'd1;
    end
    if (close) begin
      state_d[wr_sel_q] = FULL;
      idx_d             = '0;
      wr_sel_d          = ~wr_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      ovf_q      <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q  <= state_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      idx_q    <= idx_d;
    end
  end

  // The first write into an EMPTY buffer clears it, so a flushed frame's unwritten slots read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < WORDS; k++) begin
          mem_q[b][k] <= '0;
        end
      end
    end else if (accept) begin
      for (int k = 0; k < WORDS; k++) begin
        if (idx_q == 6'(k)) begin
          mem_q[wr_sel_q][k] <= store_cw;
        end else if (wr_state == EMPTY) begin
          mem_q[wr_sel_q][k] <= '0;
        end
      end
    end
  end

  always_comb begin
    frame_cw = '0;
    for (int k = 0; k < WORDS; k++) begin
      frame_cw[k*CW_W +: CW_W] = mem_q[rd_sel_q][k];
    end
  end

  assign frame_ovf = ovf_q[rd_sel_q];
  assign frame_cnt = cnt_q[rd_sel_q];

endmodule

`default_nettype wire
